fault_conf_ctrl: RTL

CAN fault-confinement controller. It consumes the threshold flags of the transmit error counter (TEC) and receive error counter (REC) and sequences the node through error-active, error-passive and bus-off. In bus-off it runs the recovery counter: 128 occurrences of 11 consecutive recessive bits. On completion it clears both error counters with a one-cycle strobe. It sits between the TEC/REC counters and the MAC FSM, which uses its state outputs to select active or passive error flags and to disable transmission.

---
 rtl/fault_conf_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fault_conf_ctrl.sv
// CAN fault-confinement controller: tracks error-active / error-passive / bus-off
// from TEC/REC threshold flags and runs the 128x11-recessive-bit bus-off recovery.
module fault_conf_ctrl #(
    parameter int BITS_PER_SEQ = 11,
    parameter int SEQ_COUNT    = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tec_ge96,
    input  logic       tec_ge128,
    input  logic       tec_ge256,
    input  logic       rec_ge96,
    input  logic       rec_ge128,
    input  logic       bit_tick,
    input  logic       rcv_bit,
    input  logic       rec_en,
    output logic       erroractive,
    output logic       errorpassive,
    output logic       busoff,
    output logic       warning,
    output logic       ctr_clr_n,
    output logic [7:0] recseq
);

    typedef enum logic [1:0] {
        ERROR_ACTIVE  = 2'd0,
        ERROR_PASSIVE = 2'd1,
        BUS_OFF       = 2'd2,
        CLEAR         = 2'd3
    } state_e;

    localparam logic [3:0] BIT_LAST = 4'(BITS_PER_SEQ - 1);
    localparam logic [7:0] SEQ_LAST = 8'(SEQ_COUNT);

    state_e     state_q, state_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [7:0] recseq_q, recseq_d;
    logic       erroractive_q, erroractive_d;
    logic       errorpassive_q, errorpassive_d;
    logic       busoff_q, busoff_d;
    logic       warning_q, warning_d;
    logic       ctr_clr_n_q, ctr_clr_n_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ERROR_ACTIVE;
            bitcnt_q       <= '0;
            recseq_q       <= '0;
            erroractive_q  <= 1'b1;
            errorpassive_q <= 1'b0;
            busoff_q       <= 1'b0;
            warning_q      <= 1'b0;
            ctr_clr_n_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            bitcnt_q       <= bitcnt_d;
            recseq_q       <= recseq_d;
            erroractive_q  <= erroractive_d;
            errorpassive_q <= errorpassive_d;
            busoff_q       <= busoff_d;
            warning_q      <= warning_d;
            ctr_clr_n_q    <= ctr_clr_n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        recseq_d = recseq_q;
        case (state_q)
            ERROR_ACTIVE: begin
                if (tec_ge256)                   state_d = BUS_OFF;
                else if (tec_ge128 || rec_ge128) state_d = ERROR_PASSIVE;
            end
            ERROR_PASSIVE: begin
                if (tec_ge256)                     state_d = BUS_OFF;
                else if (!tec_ge128 && !rec_ge128) state_d = ERROR_ACTIVE;
            end
            BUS_OFF: begin
                if (bit_tick) begin
                    if (!rec_en) begin
                        bitcnt_d = '0;
                        recseq_d = '0;
                    end else if (!rcv_bit) begin
                        bitcnt_d = '0;
                    end else if (bitcnt_q == BIT_LAST) begin
                        bitcnt_d = '0;
                        recseq_d = recseq_q + 8'd1;
                        // Completing tick enters CLEAR on the same edge; recseq holds SEQ_COUNT there.
                        if (recseq_d == SEQ_LAST) state_d = CLEAR;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end
            CLEAR: begin
                state_d  = ERROR_ACTIVE;
                bitcnt_d = '0;
                recseq_d = '0;
            end
            default: state_d = ERROR_ACTIVE;
        endcase
        if (state_q != BUS_OFF && state_d == BUS_OFF) begin
            bitcnt_d = '0;
            recseq_d = '0;
        end

        // Outputs are decoded from the next state so they leave the flops aligned with state_q.
        erroractive_d  = (state_d == ERROR_ACTIVE);
        errorpassive_d = (state_d == ERROR_PASSIVE);
        busoff_d       = (state_d == BUS_OFF) || (state_d == CLEAR);
        warning_d      = !busoff_d && (tec_ge96 || rec_ge96);
        ctr_clr_n_d    = (state_d != CLEAR);
    end

    assign erroractive  = erroractive_q;
    assign errorpassive = errorpassive_q;
    assign busoff       = busoff_q;
    assign warning      = warning_q;
    assign ctr_clr_n    = ctr_clr_n_q;
    assign recseq       = recseq_q;

endmodule
